tx_block_serializer: RTL

Transmit-side counterpart of the receive shifter/buffer pair. It accepts 128-bit AES result blocks, holds one pending block, and serialises each block MSB-byte-first into the UART transmitter (`UART_tx`) using its `din`/`tx_start`/`tx_done_flag` handshake. It sits between the AES core output and `UART_tx`, mirroring the receive path's byte-to-block assembly.

---
 rtl/uart_aes_pkg.sv | 24 ++
 rtl/tx_hold_reg.sv | 57 +++++
 rtl/tx_block_serializer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_aes_pkg.sv
// -----------------------------------------------------------------------------
// uart_aes_pkg
// Shared definitions for the UART/AES byte-to-block datapath.
//   BLOCK_W          : AES block width in bits
//   BYTE_W           : UART character width in bits
//   BYTES_PER_BLOCK  : number of UART characters per AES block
//   CNT_W            : width of a byte index within one block
//   tx_state_e       : transmit serialiser state encoding
// -----------------------------------------------------------------------------
package uart_aes_pkg;

   localparam int BLOCK_W         = 128;
   localparam int BYTE_W          = 8;
   localparam int BYTES_PER_BLOCK = BLOCK_W / BYTE_W;
   localparam int CNT_W           = $clog2(BYTES_PER_BLOCK);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_NEXT  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/tx_hold_reg.sv
// -----------------------------------------------------------------------------
// tx_hold_reg
// Single-entry holding buffer in front of the block serialiser. A write is
// accepted when the buffer is empty or when its current content is being
// taken in the same cycle; otherwise the write is dropped and the sticky
// overflow flag is raised. The flag is cleared only by reset.
//
// Ports
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   we     in   write strobe for wdata
//   wdata  in   block to store
//   take   in   serialiser consumes the stored block this cycle
//   valid  out  buffer occupied
//   data   out  stored block
//   of     out  sticky overflow (a write was dropped)
// -----------------------------------------------------------------------------
module tx_hold_reg #(
   parameter int BLOCK_W = uart_aes_pkg::BLOCK_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we,
   input  logic [BLOCK_W-1:0] wdata,
   input  logic               take,
   output logic               valid,
   output logic [BLOCK_W-1:0] data,
   output logic               of
);

   logic accept;

   // A write in the same cycle as a take refills the slot being vacated.
   assign accept = we && (!valid || take);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= 1'b0;
         data  <= '0;
         of    <= 1'b0;
      end else begin
         if (accept) begin
            data  <= wdata;
            valid <= 1'b1;
         end else begin
            if (take) begin
               valid <= 1'b0;
            end
            // Reaching here with we set means the slot was full and not drained.
            if (we) begin
               of <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/tx_block_serializer.sv
// -----------------------------------------------------------------------------
// tx_block_serializer
// Accepts BLOCK_W-bit result blocks, buffers one pending block and sends each
// block most-significant byte first through the UART transmitter handshake
// (din / tx_start / tx_done_flag).
//
// Ports
//   clk           in   system clock
//   reset         in   asynchronous active-low reset
//   block_in      in   block to transmit, sampled when we=1
//   we            in   single-cycle write strobe
//   tx_done_flag  in   pulse from the UART transmitter: byte finished
//   din           out  byte presented to the UART transmitter
//   tx_start      out  one-cycle start pulse for the UART transmitter
//   full          out  holding register occupied
//   busy          out  serialiser active (not idle)
//   of            out  sticky overflow: a write was dropped
//   block_sent    out  one-cycle pulse after the last byte of a block
// -----------------------------------------------------------------------------
module tx_block_serializer #(
   parameter int BLOCK_W = uart_aes_pkg::BLOCK_W,
   parameter int BYTE_W  = uart_aes_pkg::BYTE_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [BLOCK_W-1:0] block_in,
   input  logic               we,
   input  logic               tx_done_flag,
   output logic [BYTE_W-1:0]  din,
   output logic               tx_start,
   output logic               full,
   output logic               busy,
   output logic               of,
   output logic               block_sent
);

   import uart_aes_pkg::*;

   localparam int N_BYTES = BLOCK_W / BYTE_W;
   localparam int CW      = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam logic [CW-1:0] LAST_BYTE = CW'(N_BYTES - 1);

   tx_state_e          state;
   tx_state_e          state_nxt;
   logic [BLOCK_W-1:0] shreg;
   logic [CW-1:0]      cnt;
   logic               hold_valid;
   logic [BLOCK_W-1:0] hold_data;

   logic               take;
   logic               shift;
   logic               start_nxt;
   logic               sent_nxt;

   tx_hold_reg #(
      .BLOCK_W (BLOCK_W)
   ) u_hold (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .wdata (block_in),
      .take  (take),
      .valid (hold_valid),
      .data  (hold_data),
      .of    (of)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and per-cycle control
   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      shift     = 1'b0;
      start_nxt = 1'b0;
      sent_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (hold_valid) begin
               take      = 1'b1;
               state_nxt = ST_START;
            end
         end
         ST_START: begin
            start_nxt = 1'b1;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (tx_done_flag) begin
               state_nxt = ST_NEXT;
            end
         end
         ST_NEXT: begin
            if (cnt == LAST_BYTE) begin
               sent_nxt = 1'b1;
               // Reload straight into START so back-to-back blocks leave no gap.
               if (hold_valid) begin
                  take      = 1'b1;
                  state_nxt = ST_START;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else begin
               shift     = 1'b1;
               state_nxt = ST_START;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Shift register, byte counter and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg      <= '0;
         cnt        <= '0;
         tx_start   <= 1'b0;
         block_sent <= 1'b0;
         busy       <= 1'b0;
      end else begin
         tx_start   <= start_nxt;
         block_sent <= sent_nxt;
         busy       <= (state_nxt != ST_IDLE);
         if (take) begin
            shreg <= hold_data;
            cnt   <= '0;
         end else if (shift) begin
            shreg <= {shreg[BLOCK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            cnt   <= cnt + CW'(1);
         end
      end
   end

   // The outgoing byte is always the top of the shift register, so it holds
   // steady from START until the shift in NEXT.
   assign din  = shreg[BLOCK_W-1 -: BYTE_W];
   assign full = hold_valid;

endmodule
